// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock byte FIFO between a producer (SIPO stage) and the downstream
// PISO serializer. Holds a 2**ADDR_W x DATA_W dual-port RAM with a registered
// read port, plus write/read pointers, an occupancy counter, and registered
// full/empty status. The overflow and underflow error flags are sticky.
//
// Optional feature macro: FIFO_ALMOST_FLAGS_EN
//   defined   : almost_full  = (count >= AF_LVL), almost_empty = (count <= AE_LVL),
//               both registered together with count.
//   undefined : almost_full and almost_empty are tied to 0.
//
// Full and empty are derived from the occupancy count, not from comparing
// pointers, so the pointers only need ADDR_W bits and wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int AF_LVL = 1020,
    parameter int AE_LVL = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    // Storage array.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Control state.
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              ovf_q,    ovf_d;
    logic              unf_q,    unf_d;
    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] rdata_q;

    // Accepted accesses for this cycle.
    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    // Accept/reject decisions, pointer and occupancy next-state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = rd_acc;
        ovf_d    = ovf_q | (wr_en & full_q);
        unf_d    = unf_q | (rd_en & empty_q);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        // Push and pop in the same cycle cancel out.
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // A write issued in the reset cycle is dropped along with everything else.
    assign mem_we = wr_acc & reset_n;

    // RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing it is never needed because
        // the pointers and count are reset, and it keeps the array mappable
        // onto block RAM.
        if (mem_we) begin
            mem_mem_write : mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Registered RAM read port; o_data holds its value when nothing is popped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_q[rd_ptr_q];
        end
    end

    // Pointers, occupancy, status flags and the read-valid pulse.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LVL);

    logic af_q;
    logic ae_q;

    // Almost flags follow the next occupancy so they line up with count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= (count_d >= AF_C);
            ae_q <= (count_d <= AE_C);
        end
    end

    assign almost_full  = af_q;
    assign almost_empty = ae_q;
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    assign o_data    = rdata_q;
    assign o_valid   = valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Directed bench for sync_fifo_ctrl at the default size (8 x 1024).
// A vector table covers the basic push/pop sequence; hand-written sequences
// cover fill/overflow/drain, underflow stickiness, long pass-through with
// pointer wrap, simultaneous access at the boundaries, reset mid-operation
// and the optional almost flags (expected values follow FIFO_ALMOST_FLAGS_EN).
// Inputs change 1 ns after the rising edge and outputs are checked there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic ALM = 1'b1;
`else
    localparam logic ALM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [DATA_W-1:0] i_data;
    logic              rd_en;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              almost_full;
    logic              almost_empty;

    int pass_cnt  = 0;
    int check_cnt = 0;

    sync_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .AF_LVL (1020),
        .AE_LVL (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .i_data       (i_data),
        .rd_en        (rd_en),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         exp_count;
        logic       exp_empty;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_unf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        i_data  = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic write_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_en  = 1'b1;
            i_data = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_words(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    // Hard stop in case the bench itself stalls.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                wr    rd    din    cnt empty valid data  unf
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 8'h22, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h33, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 8'h33, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h44, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h44, 1'b1};

        // ---- reset state ----
        do_reset();
        check("rst_count",    32'(count),   0);
        check("rst_empty",    32'(empty),   1);
        check("rst_full",     32'(full),    0);
        check("rst_valid",    32'(o_valid), 0);
        check("rst_data",     32'(o_data),  0);
        check("rst_ovf",      32'(overflow),  0);
        check("rst_unf",      32'(underflow), 0);
        check("rst_afull",    32'(almost_full),  0);
        check("rst_aempty",   32'(almost_empty), 32'(ALM));

        // ---- basic push/pop table ----
        for (int i = 0; i < 10; i++) begin
            wr_en  = vecs[i].wr;
            rd_en  = vecs[i].rd;
            i_data = vecs[i].din;
            tick();
            check($sformatf("v%0d_count", i), 32'(count),     32'(vecs[i].exp_count));
            check($sformatf("v%0d_empty", i), 32'(empty),     32'(vecs[i].exp_empty));
            check($sformatf("v%0d_valid", i), 32'(o_valid),   32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data",  i), 32'(o_data),    32'(vecs[i].exp_data));
            check($sformatf("v%0d_unf",   i), 32'(underflow), 32'(vecs[i].exp_unf));
            check($sformatf("v%0d_ovf",   i), 32'(overflow),  0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // ---- fill to full, overflow, drain in order ----
        do_reset();
        write_words(DEPTH - 1, 0);
        check("fill_1023_count", 32'(count), 1023);
        check("fill_1023_full",  32'(full),  0);
        write_words(1, DEPTH - 1);
        check("fill_1024_count", 32'(count), 1024);
        check("fill_1024_full",  32'(full),  1);
        check("fill_1024_ovf",   32'(overflow), 0);
        write_words(1, 8'hAA);
        check("ovf_count", 32'(count),    1024);
        check("ovf_flag",  32'(overflow), 1);
        check("ovf_full",  32'(full),     1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
            tick();
            check($sformatf("drain%0d_valid", i), 32'(o_valid), 1);
            check($sformatf("drain%0d_data",  i), 32'(o_data),  32'(i % 256));
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
        tick();
        check("drain_idle_valid", 32'(o_valid),  0);
        check("drain_ovf_sticky", 32'(overflow), 1);

        // ---- underflow stickiness ----
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("unf_flag",  32'(underflow), 1);
        check("unf_count", 32'(count),     0);
        tick();
        check("unf_valid", 32'(o_valid),   0);
        write_words(2, 8'h50);
        read_words(2);
        tick();
        check("unf_sticky", 32'(underflow), 1);
        do_reset();
        check("unf_cleared", 32'(underflow), 0);

        // ---- steady pass-through at count 5, pointers wrap ----
        write_words(5, 0);
        check("pt_start_count", 32'(count), 5);
        for (int j = 0; j < 2000; j++) begin
            wr_en  = 1'b1;
            rd_en  = 1'b1;
            i_data = 8'(j + 5);
            tick();
            check($sformatf("pt%0d_count", j), 32'(count),   5);
            check($sformatf("pt%0d_valid", j), 32'(o_valid), 1);
            check($sformatf("pt%0d_data",  j), 32'(o_data),  32'(j % 256));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        read_words(5);
        check("pt_tail_data",  32'(o_data), 32'((2004) % 256));
        check("pt_tail_empty", 32'(empty),  1);

        // ---- simultaneous access at full ----
        do_reset();
        write_words(DEPTH, 8'h80);
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        i_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("both_full_count", 32'(count),    1023);
        check("both_full_ovf",   32'(overflow), 1);
        check("both_full_full",  32'(full),     0);
        check("both_full_valid", 32'(o_valid),  1);
        check("both_full_data",  32'(o_data),   32'h80);

        // ---- simultaneous access at empty ----
        do_reset();
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        i_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("both_empty_count", 32'(count),     1);
        check("both_empty_unf",   32'(underflow), 1);
        check("both_empty_valid", 32'(o_valid),   0);
        read_words(1);
        check("both_empty_data",  32'(o_data),    32'h5A);

        // ---- reset mid-operation with a pop in the same cycle ----
        do_reset();
        write_words(6, 8'h60);
        reset_n = 1'b0;
        rd_en   = 1'b1;
        tick();
        reset_n = 1'b1;
        rd_en   = 1'b0;
        check("midrst_count",  32'(count),   0);
        check("midrst_empty",  32'(empty),   1);
        check("midrst_valid",  32'(o_valid), 0);
        check("midrst_data",   32'(o_data),  0);
        check("midrst_aempty", 32'(almost_empty), 32'(ALM));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("midrst_no_stale_valid", 32'(o_valid), 0);

        // ---- almost flags thresholds ----
        do_reset();
        write_words(1019, 0);
        check("af_1019", 32'(almost_full), 0);
        write_words(1, 0);
        check("af_1020", 32'(almost_full), 32'(ALM));
        read_words(1015);
        check("ae_5_count", 32'(count),        5);
        check("ae_5",       32'(almost_empty), 0);
        check("af_5",       32'(almost_full),  0);
        read_words(1);
        check("ae_4",       32'(almost_empty), 32'(ALM));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
